// File: rtl/fetch_predict_unit.sv
// Fetch PC generation with a 2-bit-counter BHT and an in-order queue of outstanding branch
// predictions; resolutions from EX pop the queue, train the BHT and redirect on mispredicts.
module fetch_predict_unit #(
    parameter int unsigned     XLEN        = 32,
    parameter int unsigned     BHT_ENTRIES = 64,
    parameter int unsigned     BQ_DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC    = '0
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [31:0]                 instr,
    input  logic                        stall,
    input  logic                        res_valid,
    input  logic                        res_taken,
    input  logic [XLEN-1:0]             res_target,
    input  logic                        jalr_valid,
    input  logic [XLEN-1:0]             jalr_target,
    output logic [XLEN-1:0]             address,
    output logic                        pred_taken,
    output logic                        flush,
    output logic                        bq_full,
    output logic [$clog2(BQ_DEPTH):0]   bq_count,
    output logic                        res_err
);
    localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);
    localparam int unsigned PTR_W = $clog2(BQ_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [XLEN-1:0]  r_pc;
    logic [1:0]       r_bht [BHT_ENTRIES];
    logic [XLEN-1:0]  r_bq_pc [BQ_DEPTH];
    logic [IDX_W-1:0] r_bq_idx [BQ_DEPTH];
    logic             r_bq_pred [BQ_DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    logic             w_is_b;
    logic             w_is_jal;
    logic [XLEN-1:0]  w_b_imm;
    logic [XLEN-1:0]  w_j_imm;
    logic [IDX_W-1:0] w_idx;
    logic             w_bht_taken;
    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_mispredict;
    logic             w_flush;
    logic             w_hold;
    logic             w_push;
    logic [IDX_W-1:0] w_head_idx;
    logic [1:0]       w_ctr;
    logic [1:0]       w_ctr_next;
    logic [XLEN-1:0]  w_pc_next;

    assign w_is_b   = (instr[6:0] == 7'b1100011);
    assign w_is_jal = (instr[6:0] == 7'b1101111);
    assign w_b_imm  = {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign w_j_imm  = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21],
                       1'b0};

    assign w_idx       = r_pc[IDX_W+1:2];
    assign w_bht_taken = r_bht[w_idx][1];

    assign w_empty      = (r_count == '0);
    assign w_full       = (r_count == CNT_W'(BQ_DEPTH));
    assign w_pop        = res_valid && !w_empty;
    assign w_head_idx   = r_bq_idx[r_head];
    assign w_mispredict = w_pop && (res_taken != r_bq_pred[r_head]);
    assign w_flush      = w_mispredict || jalr_valid;
    assign w_hold       = stall || (w_is_b && w_full);
    assign w_push       = w_is_b && !w_hold && !w_flush;

    assign address    = r_pc;
    assign pred_taken = w_is_jal || (w_is_b && w_bht_taken);
    // Gated by reset_n so both stay low while reset is held, whatever the inputs do.
    assign flush      = reset_n && w_flush;
    assign res_err    = reset_n && res_valid && w_empty;
    assign bq_full    = w_full;
    assign bq_count   = r_count;

    always_comb begin
        w_ctr      = r_bht[w_head_idx];
        w_ctr_next = w_ctr;
        if (res_taken) begin
            if (w_ctr != 2'b11) w_ctr_next = w_ctr + 2'b01;
        end else begin
            if (w_ctr != 2'b00) w_ctr_next = w_ctr - 2'b01;
        end
    end

    always_comb begin
        w_pc_next = r_pc + XLEN'(4);
        if (w_mispredict) begin
            w_pc_next = res_taken ? res_target : r_bq_pc[r_head] + XLEN'(4);
        end else if (jalr_valid) begin
            w_pc_next = jalr_target;
        end else if (w_hold) begin
            w_pc_next = r_pc;
        end else if (w_is_jal) begin
            w_pc_next = r_pc + w_j_imm;
        end else if (w_is_b && w_bht_taken) begin
            w_pc_next = r_pc + w_b_imm;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++) r_bht[i] <= 2'b01;
        end else if (w_pop) begin
            r_bht[w_head_idx] <= w_ctr_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (w_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_pop)  r_head <= r_head + PTR_W'(1);
            if (w_push) r_tail <= r_tail + PTR_W'(1);
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    // Payload needs no reset: entries are only read while counted as occupied.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_bq_pc[r_tail]   <= r_pc;
            r_bq_idx[r_tail]  <= w_idx;
            r_bq_pred[r_tail] <= w_bht_taken;
        end
    end
endmodule

// File: tb/tb_fetch_predict_unit.sv
// Directed bench for fetch_predict_unit: each task drives one scenario and checks inline.
module tb_fetch_predict_unit;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] instr;
    logic        stall;
    logic        res_valid;
    logic        res_taken;
    logic [31:0] res_target;
    logic        jalr_valid;
    logic [31:0] jalr_target;
    logic [31:0] address;
    logic        pred_taken;
    logic        flush;
    logic        bq_full;
    logic [2:0]  bq_count;
    logic        res_err;

    int errors = 0;
    int checks = 0;

    logic [31:0] nop   = 32'h0000_0013;
    logic [31:0] jal_p8  = 32'h0080_006F;
    logic [31:0] jal_m16 = 32'hFF1F_F06F;
    logic [31:0] b16;
    logic [5:0]  ep  = 6'b011110;
    logic [5:0]  tk  = 6'b100111;
    logic [5:0]  fl  = 6'b111001;
    logic [31:0] pcs [6] = '{32'h30, 32'h34, 32'h34, 32'h24, 32'h24, 32'h30};

    always #5 clk = ~clk;

    fetch_predict_unit dut (
        .clk(clk), .reset_n(reset_n), .instr(instr), .stall(stall),
        .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
        .jalr_valid(jalr_valid), .jalr_target(jalr_target), .address(address),
        .pred_taken(pred_taken), .flush(flush), .bq_full(bq_full), .bq_count(bq_count),
        .res_err(res_err)
    );

    function automatic logic [31:0] b_instr(input logic [12:0] imm);
        return {imm[12], imm[10:5], 5'd0, 5'd0, 3'd0, imm[4:1], imm[11], 7'b1100011};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic goto(input logic [31:0] a);
        jalr_valid = 1'b1; jalr_target = a; instr = nop;
        tick();
        jalr_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; stall = 1'b0; res_taken = 1'b0; res_target = '0; jalr_target = '0;
        instr = jal_p8; res_valid = 1'b1; jalr_valid = 1'b1;
        #2;
        checks++; if (address !== 32'h0) begin errors++; $display("FAIL reset_addr got %h exp %h", address, 32'h0); end
        checks++; if (bq_count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", bq_count); end
        checks++; if (bq_full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", bq_full); end
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL reset_flush got %b exp 0", flush); end
        checks++; if (res_err !== 1'b0) begin errors++; $display("FAIL reset_res_err got %b exp 0", res_err); end
        checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL reset_pred_jal got %b exp 1", pred_taken); end
        res_valid = 1'b0; jalr_valid = 1'b0; instr = nop;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_sequential();
        #1;
        checks++; if (address !== 32'h0) begin errors++; $display("FAIL seq_pc0 got %h exp 0", address); end
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++; if (address !== 32'(i * 4)) begin errors++; $display("FAIL seq_pc got %h exp %h", address, 32'(i * 4)); end
            checks++; if (flush !== 1'b0) begin errors++; $display("FAIL seq_flush got %b exp 0", flush); end
        end
    endtask

    task automatic test_jal_stall();
        instr = jal_p8; #1;
        checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL jal_pred got %b exp 1", pred_taken); end
        tick();
        checks++; if (address !== 32'h14) begin errors++; $display("FAIL jal_fwd got %h exp 14", address); end
        instr = jal_m16;
        tick();
        checks++; if (address !== 32'h04) begin errors++; $display("FAIL jal_back got %h exp 04", address); end
        instr = b16; stall = 1'b1; #1;
        checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL stall_pred got %b exp 0", pred_taken); end
        tick();
        checks++; if (address !== 32'h04) begin errors++; $display("FAIL stall_hold got %h exp 04", address); end
        checks++; if (bq_count !== 3'd0) begin errors++; $display("FAIL stall_nopush got %0d exp 0", bq_count); end
        stall = 1'b0; instr = nop;
    endtask

    task automatic test_bht();
        for (int r = 0; r < 6; r++) begin
            goto(32'h20);
            instr = b16; #1;
            checks++; if (pred_taken !== ep[r]) begin errors++; $display("FAIL bht_pred[%0d] got %b exp %b", r, pred_taken, ep[r]); end
            tick();
            checks++; if (address !== (ep[r] ? 32'h30 : 32'h24)) begin errors++; $display("FAIL bht_fetch_pc[%0d] got %h exp %h", r, address, ep[r] ? 32'h30 : 32'h24); end
            checks++; if (bq_count !== 3'd1) begin errors++; $display("FAIL bht_push[%0d] got %0d exp 1", r, bq_count); end
            instr = nop; res_valid = 1'b1; res_taken = tk[r]; res_target = 32'h30; #1;
            checks++; if (flush !== fl[r]) begin errors++; $display("FAIL bht_flush[%0d] got %b exp %b", r, flush, fl[r]); end
            tick();
            res_valid = 1'b0;
            checks++; if (address !== pcs[r]) begin errors++; $display("FAIL bht_res_pc[%0d] got %h exp %h", r, address, pcs[r]); end
            checks++; if (bq_count !== 3'd0) begin errors++; $display("FAIL bht_pop[%0d] got %0d exp 0", r, bq_count); end
        end
    endtask

    task automatic test_queue_full();
        goto(32'h40);
        instr = b16;
        for (int i = 0; i < 4; i++) tick();
        checks++; if (bq_count !== 3'd4) begin errors++; $display("FAIL full_count got %0d exp 4", bq_count); end
        checks++; if (bq_full !== 1'b1) begin errors++; $display("FAIL full_flag got %b exp 1", bq_full); end
        checks++; if (address !== 32'h50) begin errors++; $display("FAIL full_pc got %h exp 50", address); end
        tick();
        checks++; if (address !== 32'h50) begin errors++; $display("FAIL full_hold got %h exp 50", address); end
        checks++; if (bq_count !== 3'd4) begin errors++; $display("FAIL full_nopush got %0d exp 4", bq_count); end
        res_valid = 1'b1; res_taken = 1'b0; #1;
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL full_res_flush got %b exp 0", flush); end
        tick();
        res_valid = 1'b0;
        checks++; if (bq_count !== 3'd3) begin errors++; $display("FAIL full_pop got %0d exp 3", bq_count); end
        checks++; if (address !== 32'h50) begin errors++; $display("FAIL full_pop_pc got %h exp 50", address); end
        tick();
        checks++; if (bq_count !== 3'd4) begin errors++; $display("FAIL full_refill got %0d exp 4", bq_count); end
        checks++; if (address !== 32'h54) begin errors++; $display("FAIL full_advance got %h exp 54", address); end
        instr = nop;
    endtask

    task automatic test_jalr();
        goto(32'h60);
        checks++; if (bq_count !== 3'd0) begin errors++; $display("FAIL jalr_clear4 got %0d exp 0", bq_count); end
        instr = b16;
        tick(); tick();
        checks++; if (bq_count !== 3'd2) begin errors++; $display("FAIL jalr_prefill got %0d exp 2", bq_count); end
        instr = nop; jalr_valid = 1'b1; jalr_target = 32'h100; #1;
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL jalr_flush got %b exp 1", flush); end
        tick();
        jalr_valid = 1'b0;
        checks++; if (bq_count !== 3'd0) begin errors++; $display("FAIL jalr_clear got %0d exp 0", bq_count); end
        checks++; if (address !== 32'h100) begin errors++; $display("FAIL jalr_pc got %h exp 100", address); end
    endtask

    task automatic test_res_err();
        res_valid = 1'b1; res_taken = 1'b1; res_target = 32'h200; #1;
        checks++; if (res_err !== 1'b1) begin errors++; $display("FAIL res_err_pulse got %b exp 1", res_err); end
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL res_err_flush got %b exp 0", flush); end
        tick();
        res_valid = 1'b0; #1;
        checks++; if (address !== 32'h104) begin errors++; $display("FAIL res_err_pc got %h exp 104", address); end
        checks++; if (res_err !== 1'b0) begin errors++; $display("FAIL res_err_end got %b exp 0", res_err); end
        checks++; if (bq_count !== 3'd0) begin errors++; $display("FAIL res_err_count got %0d exp 0", bq_count); end
    endtask

    task automatic test_reset_mid();
        goto(32'h30);
        instr = b16;
        tick();
        checks++; if (bq_count !== 3'd1) begin errors++; $display("FAIL mid_push got %0d exp 1", bq_count); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (bq_count !== 3'd0) begin errors++; $display("FAIL mid_count got %0d exp 0", bq_count); end
        checks++; if (address !== 32'h0) begin errors++; $display("FAIL mid_pc got %h exp 0", address); end
        @(negedge clk);
        reset_n = 1'b1;
        goto(32'h20);
        instr = b16; #1;
        checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL mid_bht got %b exp 0", pred_taken); end
        instr = nop;
    endtask

    initial begin
        b16 = b_instr(13'd16);
        test_reset();
        test_sequential();
        test_jal_stall();
        test_bht();
        test_queue_full();
        test_jalr();
        test_res_err();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fetch_predict_unit.md
FETCH_PREDICT_UNIT -- requirements
Module: fetch_predict_unit

Interface
REQ-001 Parameter XLEN, 32, address/data width.
REQ-002 Parameter BHT_ENTRIES, 64, number of 2-bit counters; power of 2, >= 4.
REQ-003 Parameter BQ_DEPTH, 4, branch-queue depth; power of 2, >= 2.
REQ-004 Parameter RESET_PC, 0, PC value after reset.
REQ-005 clk  in  1  clock; all state SHALL update on rising edge.
REQ-006 reset_n  in  1  reset, asynchronous, active-low.
REQ-007 instr  in  32  instruction word at address, same cycle.
REQ-008 stall  in  1  hold PC; no queue push.
REQ-009 res_valid  in  1  EX resolved the oldest outstanding B-type branch.
REQ-010 res_taken  in  1  actual branch outcome.
REQ-011 res_target  in  XLEN  actual taken target.
REQ-012 jalr_valid  in  1  EX resolved a JALR.
REQ-013 jalr_target  in  XLEN  JALR destination.
REQ-014 address  out  XLEN  current fetch PC (pc_reg).
REQ-015 pred_taken  out  1  prediction for the instr at address (1 for JAL, 0 for non-branches).
REQ-016 flush  out  1  kill IF/ID and ID/EX this cycle (combinational).
REQ-017 bq_full  out  1  branch queue holds BQ_DEPTH entries.
REQ-018 bq_count  out  log2(BQ_DEPTH)+1  queue occupancy.
REQ-019 res_err  out  1  one-cycle pulse: res_valid while queue empty.

Function
REQ-020 Decode: opcode 1100011 = B-type, 1101111 = JAL; immediates per RV32I, sign-extended to XLEN.
REQ-021 BHT index = address[log2(BHT_ENTRIES)+1:2]; predict taken iff counter[1]=1.
REQ-022 Next-PC priority: (1) mispredict redirect, (2) jalr_valid -> jalr_target, (3) stall or (B-type and bq_full) -> hold, (4) JAL -> address+imm, (5) B-type predicted taken -> address+imm, (6) address+4.
REQ-023 Push: B-type fetched, not held, no flush -> enqueue {address, BHT index, prediction}.
REQ-024 Pop: res_valid with queue non-empty removes head; mispredict = res_taken != head prediction.
REQ-025 Mispredict redirect: res_taken ? res_target : head.pc+4; flush=1; queue cleared same edge.
REQ-026 jalr_valid: flush=1; queue cleared; no push that cycle.
REQ-027 Correct prediction: flush=0; only head popped.
REQ-028 Each pop updates counter[head.index] saturating: taken -> +1 max 3, not taken -> -1 min 0.
REQ-029 Lookup and update of same index in the same cycle: lookup SHALL use pre-update value.
REQ-030 Pop and push in the same cycle without flush: count unchanged, order preserved.
REQ-031 Pointers SHALL wrap modulo BQ_DEPTH; bq_count SHALL never exceed BQ_DEPTH nor underflow.
REQ-032 res_valid on empty queue: no BHT update, no redirect, res_err=1 for that cycle.
REQ-033 jalr_valid and res_valid together: mispredict (if any) wins the PC; the BHT update still occurs; queue cleared.
REQ-034 All PC arithmetic modulo 2^XLEN; PC bits [1:0] are never checked.

Reset
REQ-035 During reset_n=0: address=RESET_PC, all counters=01 (weakly not taken), queue empty, bq_count=0, bq_full=0.
REQ-036 flush, res_err SHALL be 0 in reset; pred_taken reflects decode of instr only.
REQ-037 Reset asserted mid-operation SHALL discard queue and BHT history immediately, asynchronously.

Verification
REQ-038 Reset, feed NOPs 3 cycles -> address 0,4,8,12; flush=0.
REQ-039 B-type imm=+16 at PC 0x20, counter 01 -> pred_taken=0, next 0x24; res_valid taken, target 0x30 -> flush=1, next PC 0x30, counter=10.
REQ-040 Same branch resolved taken twice more -> counter 11; next fetch at 0x20 -> pred_taken=1, next PC 0x30; res taken -> flush=0.
REQ-041 Fetch 5 B-type branches with no resolve, BQ_DEPTH=4 -> bq_full=1 after 4, PC holds at 5th; one res_valid correct -> 5th pushed, count stays 4.
REQ-042 jalr_valid target 0x100 with 2 queued entries -> flush=1, bq_count=0, next PC 0x100.
REQ-043 res_valid with empty queue -> res_err pulse 1 cycle, PC +4, all counters unchanged.
